// File: rtl/regbank_pkg.sv
// rtl/regbank_pkg.sv - shared defaults and helpers for the register-bank write arbiter
package regbank_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 4;
    localparam int AW_DEF    = 2;

    // Ceiling log2, used to size addresses and pointers. Returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/regbank_wr_arbiter_rr_pick.sv
// rtl/regbank_wr_arbiter_rr_pick.sv - combinational round-robin picker
//
// Purpose: choose the first set bit of i_eligible, searching upward from
// i_ptr and wrapping from N-1 back to 0.
// Ports:
//   i_eligible   N   candidate bitmap
//   i_ptr        PW  index where the search starts
//   o_win_valid  1   some candidate exists
//   o_win_idx    PW  index of the winner (0 when none)
module rr_pick
    import regbank_pkg::*;
#(
    parameter int N  = N_REQ_DEF,
    parameter int PW = 2
) (
    input  logic [N-1:0]  i_eligible,
    input  logic [PW-1:0] i_ptr,
    output logic          o_win_valid,
    output logic [PW-1:0] o_win_idx
);

    // Walk the offsets from farthest to nearest so the nearest hit is the
    // last assignment and wins, avoiding a break in the loop.
    always_comb begin
        int j;
        o_win_valid = 1'b0;
        o_win_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(i_ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (i_eligible[j]) begin
                o_win_valid = 1'b1;
                o_win_idx   = PW'(j);
            end
        end
    end

endmodule

// File: rtl/regbank_wr_arbiter.sv
// rtl/regbank_wr_arbiter.sv - round-robin write arbiter in front of a shared register bank
//
// Purpose: each cycle grant one pending requester, decode its address to a
// one-hot register enable and present its data to the bank, all registered.
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_req            N_REQ        level requests, held until granted
//   i_addr_flat      N_REQ*AW     requester i address at [i*AW +: AW]
//   i_data_flat      N_REQ*WIDTH  requester i data at [i*WIDTH +: WIDTH]
//   o_gnt            N_REQ        one-hot grant, one cycle per accepted write
//   o_reg_en         DEPTH        one-hot register enable to the bank
//   o_reg_d          WIDTH        write data to the bank
//   o_addr_err       1            granted address was outside the bank
//   o_busy           1            any request pending (combinational)
module regbank_wr_arbiter
    import regbank_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [N_REQ*AW-1:0]    i_addr_flat,
    input  logic [N_REQ*WIDTH-1:0] i_data_flat,
    output logic [N_REQ-1:0]       o_gnt,
    output logic [DEPTH-1:0]       o_reg_en,
    output logic [WIDTH-1:0]       o_reg_d,
    output logic                   o_addr_err,
    output logic                   o_busy
);

    localparam int PW = (clog2(N_REQ) < 1) ? 1 : clog2(N_REQ);

    logic [N_REQ-1:0] r_gnt;
    logic [DEPTH-1:0] r_reg_en;
    logic [WIDTH-1:0] r_reg_d;
    logic             r_addr_err;
    logic [PW-1:0]    r_ptr;

    logic [N_REQ-1:0] w_elig;
    logic             w_win_valid;
    logic [PW-1:0]    w_win_idx;
    logic [AW-1:0]    w_addr;
    logic [WIDTH-1:0] w_data;
    logic             w_in_range;
    logic [DEPTH-1:0] w_dec;
    logic [N_REQ-1:0] w_gnt_nxt;
    logic [PW-1:0]    w_ptr_nxt;

    // The grant being driven this cycle doubles as the last-grant mask: a
    // requester still holding req during its grant cycle is not re-granted.
    assign w_elig = i_req & ~r_gnt;

    rr_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_rr_pick (
        .i_eligible  (w_elig),
        .i_ptr       (r_ptr),
        .o_win_valid (w_win_valid),
        .o_win_idx   (w_win_idx)
    );

    always_comb begin
        w_addr     = i_addr_flat[int'(w_win_idx)*AW +: AW];
        w_data     = i_data_flat[int'(w_win_idx)*WIDTH +: WIDTH];
        w_in_range = (int'(w_addr) < DEPTH);
        w_dec      = '0;
        for (int d = 0; d < DEPTH; d++) begin
            w_dec[d] = w_in_range && (int'(w_addr) == d);
        end
        w_gnt_nxt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_gnt_nxt[i] = w_win_valid && (int'(w_win_idx) == i);
        end
        w_ptr_nxt = (int'(w_win_idx) == N_REQ - 1) ? '0 : w_win_idx + PW'(1);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_gnt      <= '0;
            r_reg_en   <= '0;
            r_reg_d    <= '0;
            r_addr_err <= 1'b0;
            r_ptr      <= '0;
        end else begin
            r_gnt <= w_gnt_nxt;
            if (w_win_valid) begin
                // Out-of-range writes are still granted so the request is
                // consumed; only the bank enable is suppressed.
                r_reg_en   <= w_dec;
                r_addr_err <= !w_in_range;
                r_reg_d    <= w_data;
                r_ptr      <= w_ptr_nxt;
            end else begin
                r_reg_en   <= '0;
                r_addr_err <= 1'b0;
            end
        end
    end

    assign o_gnt      = r_gnt;
    assign o_reg_en   = r_reg_en;
    assign o_reg_d    = r_reg_d;
    assign o_addr_err = r_addr_err;
    assign o_busy     = |i_req;

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// tb/tb_regbank_wr_arbiter.sv - self-checking bench for regbank_wr_arbiter
module tb_regbank_wr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [7:0]  addr_flat;
    logic [31:0] data_flat;

    logic [3:0]  gnt4, gnt3;
    logic [3:0]  en4;
    logic [2:0]  en3;
    logic [7:0]  d4, d3;
    logic        err4, err3;
    logic        busy4, busy3;

    int n_chk;
    int n_fail;

    // Model state
    int         m_ptr;
    int         m_last;
    logic [7:0] m_d;
    logic [7:0] m_bank [4];
    logic       p_we;
    int         p_a;
    logic [7:0] p_d;

    logic [7:0] bank [4];

    regbank_wr_arbiter #(.N_REQ(4), .WIDTH(8), .DEPTH(4), .AW(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_addr_flat(addr_flat),
        .i_data_flat(data_flat), .o_gnt(gnt4), .o_reg_en(en4), .o_reg_d(d4),
        .o_addr_err(err4), .o_busy(busy4)
    );

    regbank_wr_arbiter #(.N_REQ(4), .WIDTH(8), .DEPTH(3), .AW(2)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_addr_flat(addr_flat),
        .i_data_flat(data_flat), .o_gnt(gnt3), .o_reg_en(en3), .o_reg_d(d3),
        .o_addr_err(err3), .o_busy(busy3)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) bank[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) if (en4[i]) bank[i] <= d4;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_last = -1;
        m_d    = '0;
        p_we   = 1'b0;
        p_a    = 0;
        p_d    = '0;
        for (int i = 0; i < 4; i++) m_bank[i] = '0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"}, 32'(gnt4), 0);
        chk({tag, "_en"},  32'(en4), 0);
        chk({tag, "_d"},   32'(d4), 0);
        chk({tag, "_err"}, 32'(err4), 0);
        chk({tag, "_gnt3"}, 32'(gnt3), 0);
        chk({tag, "_err3"}, 32'(err3), 0);
    endtask

    task automatic set_req(input int i, input int a, input logic [7:0] d);
        req[i] = 1'b1;
        addr_flat[i*2 +: 2] = 2'(a);
        data_flat[i*8 +: 8] = d;
    endtask

    // One clock: predict from the rules, advance, compare both instances.
    task automatic step();
        int w;
        int a;
        int c;
        logic [3:0] e_gnt;
        logic [3:0] e_en4;
        logic [2:0] e_en3;
        logic       e_err3;
        logic [7:0] e_d;
        w = -1;
        a = 0;
        for (int k = 0; k < 4; k++) begin
            c = (m_ptr + k) % 4;
            if (w < 0 && req[c] && c != m_last) w = c;
        end
        e_gnt = '0; e_en4 = '0; e_en3 = '0; e_err3 = 1'b0; e_d = m_d;
        if (w >= 0) begin
            e_gnt[w] = 1'b1;
            a = int'(addr_flat[w*2 +: 2]);
            e_d = data_flat[w*8 +: 8];
            e_en4[a] = 1'b1;
            if (a < 3) e_en3[a] = 1'b1;
            else e_err3 = 1'b1;
        end
        if (p_we) m_bank[p_a] = p_d;
        @(posedge clk);
        #1;
        chk("gnt", 32'(gnt4), 32'(e_gnt));
        chk("reg_en", 32'(en4), 32'(e_en4));
        chk("reg_d", 32'(d4), 32'(e_d));
        chk("addr_err", 32'(err4), 0);
        chk("gnt3", 32'(gnt3), 32'(e_gnt));
        chk("reg_en3", 32'(en3), 32'(e_en3));
        chk("addr_err3", 32'(err3), 32'(e_err3));
        chk("reg_d3", 32'(d3), 32'(e_d));
        chk("busy", 32'(busy4), 32'(|req));
        chk("gnt_onehot0", 32'($onehot0(gnt4)), 1);
        chk("en_onehot0", 32'($onehot0(en4)), 1);
        chk("en_implies_gnt", 32'((en4 == 0) || (gnt4 != 0)), 1);
        for (int i = 0; i < 4; i++) chk($sformatf("bank%0d", i), 32'(bank[i]), 32'(m_bank[i]));
        p_we   = (w >= 0);
        p_a    = a;
        p_d    = e_d;
        m_d    = e_d;
        m_last = w;
        if (w >= 0) m_ptr = (w + 1) % 4;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        model_reset();
        rst = 1'b1;
        req = 4'b1111;
        addr_flat = {2'd3, 2'd2, 2'd1, 2'd0};
        data_flat = 32'h44_33_22_11;

        // Reset held for 100 ns with all requesting
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk_zero("reset");
        end
        rst = 1'b0;

        // Full contention: expect 0,1,2,3,0,1,2,3
        for (int k = 0; k < 8; k++) begin
            step();
            chk("contend_seq", 32'(gnt4), 32'(4'b0001 << (k % 4)));
            chk("contend_en", 32'(en4), 32'(4'b0001 << (k % 4)));
        end
        req = '0;
        step();
        step();

        // Single write held through its grant cycle
        set_req(2, 3, 8'hA5);
        step();
        chk("single_gnt", 32'(gnt4), 32'h4);
        chk("single_en", 32'(en4), 32'h8);
        chk("single_d", 32'(d4), 32'hA5);
        step();
        chk("single_mask", 32'(gnt4), 0);
        req = '0;
        step();
        step();
        chk("single_bank", 32'(bank[3]), 32'hA5);

        // Out-of-range on the DEPTH=3 instance, then pointer check
        set_req(1, 3, 8'h5C);
        step();
        chk("oor_gnt3", 32'(gnt3), 32'h2);
        chk("oor_en3", 32'(en3), 0);
        chk("oor_err3", 32'(err3), 1);
        req = '0;
        step();
        chk("oor_err3_pulse", 32'(err3), 0);
        set_req(0, 0, 8'h01);
        set_req(2, 1, 8'h02);
        step();
        chk("oor_ptr", 32'(gnt3), 32'h4);
        req = '0;
        step();
        step();

        // Async reset between edges after the second grant
        set_req(0, 0, 8'h10); set_req(1, 1, 8'h20);
        set_req(2, 2, 8'h30); set_req(3, 3, 8'h40);
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        chk_zero("async_hold");
        rst = 1'b0;
        step();
        chk("restart_gnt", 32'(gnt4), 32'h1);

        // Random traffic; requests stay stable until granted
        for (int n = 0; n < 100; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (req[i] && m_last == i) begin
                    if ($urandom_range(1) == 1) req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(1) == 1) begin
                    set_req(i, int'($urandom_range(3)), 8'($urandom));
                end
            end
            step();
        end
        req = '0;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
